pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Hazard controller for the 5-stage pipeline around the decode stage.
//  - Keeps shadow copies of the destination and control fields for the E, M and W stages.
//  - Drives operand forwarding into E.
//  - Inserts load-use bubbles and flushes wrong-path instructions on a taken branch.
//  - Freezes the pipeline while data memory is busy.
//  - Counts stall and flush cycles for performance analysis.
// PARAMETERS
//  CNT_W  32  width of the saturating performance counters
//  XZR    31  zero-register index; never a hazard source or target
// PORTS
//  clk           in   1      pipeline clock
//  reset         in   1      asynchronous, active-low reset
//  valid_D       in   1      decode stage holds a real instruction
//  rs1_D         in   5      first source register of the D instruction
//  rs2_D         in   5      second source register (after reg2loc select)
//  rd_D          in   5      destination register of the D instruction
//  regWrite_D    in   1      D instruction writes rd_D
//  memRead_D     in   1      D instruction is a load
//  memAccess_M   in   1      M-stage instruction accesses data memory
//  mem_ready     in   1      data memory done; low = M access still in progress
//  branch_M      in   1      branch resolved taken in M
//  stall_F       out  1      hold PC
//  stall_D       out  1      hold IF/ID register
//  stall_EM      out  1      hold ID/EX and EX/MEM registers
//  flush_D       out  1      clear IF/ID to a bubble
//  flush_E       out  1      clear ID/EX to a bubble
//  flush_M       out  1      clear EX/MEM to a bubble
//  bubble_W      out  1      MEM/WB receives a bubble
//  fwdA_E        out  2      forward select, operand A: 00 regfile, 10 M result, 01 W result
//  fwdB_E        out  2      forward select, operand B: same encoding as fwdA_E
//  stall_cnt     out  CNT_W  cycles with stall_F high
//  flush_cnt     out  CNT_W  cycles with branch_M acted on
// BEHAVIOUR
//  Reset
//  - While reset=0:
//    - All shadow stage valids are 0.
//    - Every stall/flush/bubble output is 0.
//    - fwdA_E and fwdB_E are 00.
//    - Both counters are 0.
//  - A reset asserted mid-operation clears all shadow stages immediately, with no partial flush.
//  Shadow stages
//  - E holds {valid, rd, regWrite, memRead, rs1, rs2}.
//  - M and W each hold {valid, rd, regWrite}.
//  - Stages advance on the rising clk edge unless frozen.
//  - A flushed or bubbled stage loads valid=0.
//  Register matching
//  - "writes r" means valid & regWrite & rd==r & r!=XZR.
//  Forwarding (combinational from the shadow state)
//  - fwdA_E = 10 if M writes E.rs1; else 01 if W writes E.rs1; else 00. M has priority.
//  - fwdB_E is computed the same way on E.rs2.
//  - W-to-D hazards are not handled here; the regfile writes before it is read.
//  Priority, highest first, evaluated every cycle
//  1. Memory wait: memAccess_M & ~mem_ready & M.valid.
//     - stall_F, stall_D and stall_EM are 1; bubble_W is 1.
//     - branch_M is ignored until the wait ends.
//  2. Branch taken: branch_M & M.valid.
//     - flush_D, flush_E and flush_M are 1; no stalls.
//     - Shadow E and M go invalid.
//     - Overrides a simultaneous load-use hazard, because that instruction is squashed.
//  3. Load-use: E.valid & E.memRead, and E writes (rs1_D or rs2_D), with valid_D.
//     - stall_F and stall_D are 1; flush_E is 1 (bubble into E).
//     - Exactly one bubble per load; the next cycle re-evaluates with the load in M.
//  4. Otherwise all control outputs are 0 and the pipeline advances.
//  Stall and flush outputs are combinational on the current inputs and state (zero latency).
//  Counters
//  - stall_cnt increments each cycle stall_F=1; flush_cnt increments each cycle case 2 fires.
//  - Both saturate at 2^CNT_W-1 and never wrap.
//  Boundaries
//  - A source of XZR never stalls or forwards.
//  - A load writing XZR never causes a stall.
//  - valid_D=0 never stalls.
//  - A mem wait of K cycles yields exactly K stall cycles, and K bubbles into W.
// TESTING
//  1. ADD x1 in M, SUB reads x1 in E -> fwdA_E=10. The same ADD in W -> fwdA_E=01.
//     Both M and W write x1 -> 10.
//  2. LDUR x2 in E; D reads rs2_D=2 -> one cycle of stall_F=stall_D=flush_E=1,
//     then fwdB_E=10 is not asserted and, with the load in W, fwdB_E=01; stall_cnt=1.
//  3. branch_M=1 in the same cycle as a load-use match -> flush_D/E/M=1, stall_F=0, flush_cnt=1.
//  4. Load in M with mem_ready low for 3 cycles -> stall_F/D/EM=1 and bubble_W=1 for exactly
//     3 cycles; a branch_M asserted during the wait is acted on only after mem_ready rises.
//  5. LDUR xzr in E, D reads x31 -> no stall, fwd=00.
//     reset pulsed low mid-stall -> all outputs 0 asynchronously, counters 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard controller around decode: shadows the E/M/W destination fields, selects
// forwarding into E, and drives stall/flush/bubble controls plus saturating counters.
module pipeline_ctrl #(
   parameter int CNT_W = 32,
   parameter int XZR   = 31
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_D,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic [4:0]       rd_D,
   input  logic             regWrite_D,
   input  logic             memRead_D,
   input  logic             memAccess_M,
   input  logic             mem_ready,
   input  logic             branch_M,
   output logic             stall_F,
   output logic             stall_D,
   output logic             stall_EM,
   output logic             flush_D,
   output logic             flush_E,
   output logic             flush_M,
   output logic             bubble_W,
   output logic [1:0]       fwdA_E,
   output logic [1:0]       fwdB_E,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } e_stage_t;

   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic       wr;
   } mw_stage_t;

   localparam logic [4:0] ZR = 5'(XZR);
   // Bubbles carry XZR sources so a squashed slot in E can never select a forward.
   localparam e_stage_t  E_BUBBLE = {1'b0, ZR, 1'b0, 1'b0, ZR, ZR};
   localparam mw_stage_t M_BUBBLE = {1'b0, ZR, 1'b0};

   e_stage_t   e_q, e_d;
   mw_stage_t  m_q, m_d, w_q, w_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic mem_wait, br_take, ld_use;

   function automatic logic writes(input logic vld, input logic wr,
                                   input logic [4:0] rd, input logic [4:0] r);
      return vld & wr & (rd == r) & (r != ZR);
   endfunction

   assign mem_wait = memAccess_M & ~mem_ready & m_q.vld;
   assign br_take  = ~mem_wait & branch_M & m_q.vld;
   assign ld_use   = ~mem_wait & ~br_take & valid_D & e_q.ld &
                     (writes(e_q.vld, e_q.wr, e_q.rd, rs1_D) |
                      writes(e_q.vld, e_q.wr, e_q.rd, rs2_D));

   assign stall_F   = mem_wait | ld_use;
   assign stall_D   = mem_wait | ld_use;
   assign stall_EM  = mem_wait;
   assign flush_D   = br_take;
   assign flush_E   = br_take | ld_use;
   assign flush_M   = br_take;
   assign bubble_W  = mem_wait;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   always_comb begin
      fwdA_E = 2'b00;
      fwdB_E = 2'b00;
      if (writes(m_q.vld, m_q.wr, m_q.rd, e_q.rs1))      fwdA_E = 2'b10;
      else if (writes(w_q.vld, w_q.wr, w_q.rd, e_q.rs1)) fwdA_E = 2'b01;
      if (writes(m_q.vld, m_q.wr, m_q.rd, e_q.rs2))      fwdB_E = 2'b10;
      else if (writes(w_q.vld, w_q.wr, w_q.rd, e_q.rs2)) fwdB_E = 2'b01;
   end

   // A memory wait freezes E and M in place while W drains into bubbles.
   always_comb begin
      e_d = e_q;
      m_d = m_q;
      w_d = M_BUBBLE;
      if (!mem_wait) begin
         w_d = m_q;
         if (br_take) begin
            e_d = E_BUBBLE;
            m_d = M_BUBBLE;
         end else begin
            m_d = {e_q.vld, e_q.rd, e_q.wr};
            e_d = ld_use ? E_BUBBLE
                         : {valid_D, rd_D, regWrite_D, memRead_D, rs1_D, rs2_D};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_q         <= E_BUBBLE;
         m_q         <= M_BUBBLE;
         w_q         <= M_BUBBLE;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
         w_q <= w_d;
         if (stall_F && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (br_take && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, hand sequences for memory wait,
// counter saturation and async reset, then random stimulus against a stage model.
module tb_pipeline_ctrl;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic clk = 1'b0, reset = 1'b0;
   logic valid_D = 0, regWrite_D = 0, memRead_D = 0, memAccess_M = 0, mem_ready = 1, branch_M = 0;
   logic [4:0] rs1_D = 0, rs2_D = 0, rd_D = 0;
   logic stall_F, stall_D, stall_EM, flush_D, flush_E, flush_M, bubble_W;
   logic [1:0] fwdA_E, fwdB_E;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [6:0] ctl_o;

   int checks = 0, errors = 0;

   pipeline_ctrl #(.CNT_W(CW), .XZR(31)) dut (
      .clk(clk), .reset(reset), .valid_D(valid_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
      .rd_D(rd_D), .regWrite_D(regWrite_D), .memRead_D(memRead_D),
      .memAccess_M(memAccess_M), .mem_ready(mem_ready), .branch_M(branch_M),
      .stall_F(stall_F), .stall_D(stall_D), .stall_EM(stall_EM), .flush_D(flush_D),
      .flush_E(flush_E), .flush_M(flush_M), .bubble_W(bubble_W), .fwdA_E(fwdA_E),
      .fwdB_E(fwdB_E), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   always #5 clk = ~clk;
   assign ctl_o = {stall_F, stall_D, stall_EM, flush_D, flush_E, flush_M, bubble_W};

   // ctl = {stall_F, stall_D, stall_EM, flush_D, flush_E, flush_M, bubble_W}
   localparam logic [6:0] C0 = 7'b0000000, LU = 7'b1100100, BR = 7'b0001110, MW = 7'b1110001;

   typedef struct {
      logic vd; logic [4:0] rs1, rs2, rd; logic rw, mr, br;
      logic [6:0] ctl; logic [1:0] fa, fb;
   } vec_t;

   function automatic vec_t v(logic vd, int rs1, int rs2, int rd, logic rw, logic mr,
                              logic br, logic [6:0] ctl, logic [1:0] fa, logic [1:0] fb);
      vec_t r;
      r.vd = vd; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
      r.rw = rw; r.mr = mr; r.br = br; r.ctl = ctl; r.fa = fa; r.fb = fb;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic vd, input int rs1, input int rs2, input int rd,
                        input logic rw, input logic mr, input logic ma, input logic rdy,
                        input logic br);
      valid_D = vd; rs1_D = 5'(rs1); rs2_D = 5'(rs2); rd_D = 5'(rd);
      regWrite_D = rw; memRead_D = mr; memAccess_M = ma; mem_ready = rdy; branch_M = br;
   endtask

   task automatic nop(input logic ma, input logic rdy, input logic br);
      drive(1'b0, 31, 31, 31, 1'b0, 1'b0, ma, rdy, br);
   endtask

   // Check outputs mid-cycle, then advance to just after the next rising edge.
   task automatic step(input string nm, input logic [6:0] ectl, input logic [1:0] efa,
                       input logic [1:0] efb);
      @(negedge clk);
      chk({nm, " ctl"}, 32'(ctl_o), 32'(ectl));
      chk({nm, " fwdA"}, 32'(fwdA_E), 32'(efa));
      chk({nm, " fwdB"}, 32'(fwdB_E), 32'(efb));
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      nop(1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   // Reference model: one record per shadow stage, advanced by the hazard rules.
   typedef struct { bit v; int rd; bit w; bit ld; int rs1; int rs2; } inst_t;

   function automatic inst_t empty_i();
      inst_t e;
      e.v = 0; e.rd = 31; e.w = 0; e.ld = 0; e.rs1 = 31; e.rs2 = 31;
      return e;
   endfunction

   function automatic bit wr_r(inst_t s, int r);
      return s.v && s.w && s.rd == r && r != 31;
   endfunction

   function automatic int fsel(inst_t m, inst_t w, int r);
      return wr_r(m, r) ? 2 : (wr_r(w, r) ? 1 : 0);
   endfunction

   function automatic int rreg();
      int x = int'($urandom_range(0, 3));
      return (x == 3) ? 31 : x + 1;
   endfunction

   vec_t tbl[19];

   initial begin
      tbl[0]  = v(1, 5, 6, 1, 1, 0, 0, C0, 2'b00, 2'b00);
      tbl[1]  = v(1, 8, 9, 4, 1, 0, 0, C0, 2'b00, 2'b00);
      tbl[2]  = v(1, 1, 7, 3, 1, 0, 0, C0, 2'b00, 2'b00);
      tbl[3]  = v(1, 12, 13, 1, 1, 0, 0, C0, 2'b01, 2'b00);
      tbl[4]  = v(1, 14, 15, 1, 1, 0, 0, C0, 2'b00, 2'b00);
      tbl[5]  = v(1, 1, 1, 3, 1, 0, 0, C0, 2'b00, 2'b00);
      tbl[6]  = v(0, 31, 31, 31, 0, 0, 0, C0, 2'b10, 2'b10);
      tbl[7]  = v(1, 20, 21, 2, 1, 1, 0, C0, 2'b00, 2'b00);
      tbl[8]  = v(1, 22, 2, 5, 1, 0, 0, LU, 2'b00, 2'b00);
      tbl[9]  = v(1, 22, 2, 5, 1, 0, 0, C0, 2'b00, 2'b00);
      tbl[10] = v(0, 31, 31, 31, 0, 0, 0, C0, 2'b00, 2'b01);
      tbl[11] = v(1, 24, 25, 6, 1, 0, 0, C0, 2'b00, 2'b00);
      tbl[12] = v(1, 26, 27, 7, 1, 1, 0, C0, 2'b00, 2'b00);
      tbl[13] = v(1, 7, 8, 9, 1, 0, 1, BR, 2'b00, 2'b00);
      tbl[14] = v(0, 31, 31, 31, 0, 0, 0, C0, 2'b00, 2'b00);
      tbl[15] = v(1, 28, 29, 31, 1, 1, 0, C0, 2'b00, 2'b00);
      tbl[16] = v(1, 31, 31, 9, 1, 0, 0, C0, 2'b00, 2'b00);
      tbl[17] = v(1, 0, 0, 10, 1, 1, 0, C0, 2'b00, 2'b00);
      tbl[18] = v(0, 10, 10, 11, 1, 0, 0, C0, 2'b00, 2'b00);

      // Reset state
      @(negedge clk);
      chk("reset ctl", 32'(ctl_o), 0);
      chk("reset fwd", 32'({fwdA_E, fwdB_E}), 0);
      chk("reset cnt", 32'({stall_cnt, flush_cnt}), 0);
      @(posedge clk); #1;
      reset = 1'b1;

      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].vd, int'(tbl[i].rs1), int'(tbl[i].rs2), int'(tbl[i].rd),
               tbl[i].rw, tbl[i].mr, 1'b0, 1'b1, tbl[i].br);
         step($sformatf("vec%0d", i), tbl[i].ctl, tbl[i].fa, tbl[i].fb);
      end
      chk("tbl stall_cnt", 32'(stall_cnt), 1);
      chk("tbl flush_cnt", 32'(flush_cnt), 1);

      // Memory wait of 3 cycles with a branch pending throughout
      do_reset();
      drive(1, 20, 21, 2, 1, 1, 0, 1, 0); step("mw ld", C0, 2'b00, 2'b00);
      nop(0, 1, 0);                       step("mw nop", C0, 2'b00, 2'b00);
      for (int k = 0; k < 3; k++) begin
         nop(1, 0, 1); step($sformatf("mw wait%0d", k), MW, 2'b00, 2'b00);
      end
      nop(1, 1, 1); step("mw branch", BR, 2'b00, 2'b00);
      nop(0, 1, 0); step("mw after", C0, 2'b00, 2'b00);
      chk("mw stall_cnt", 32'(stall_cnt), 3);
      chk("mw flush_cnt", 32'(flush_cnt), 1);

      // Long wait saturates stall_cnt, then reset hits mid-stall
      drive(1, 20, 21, 2, 1, 1, 0, 1, 0); step("sat ld", C0, 2'b00, 2'b00);
      nop(0, 1, 0);                       step("sat nop", C0, 2'b00, 2'b00);
      for (int k = 0; k < 20; k++) begin
         nop(1, 0, 0); step($sformatf("sat wait%0d", k), MW, 2'b00, 2'b00);
      end
      chk("sat stall_cnt", 32'(stall_cnt), SAT);
      #2 reset = 1'b0;
      #1;
      chk("async rst ctl", 32'(ctl_o), 0);
      chk("async rst fwd", 32'({fwdA_E, fwdB_E}), 0);
      chk("async rst cnt", 32'({stall_cnt, flush_cnt}), 0);
      @(posedge clk); #1;
      nop(0, 1, 0);
      reset = 1'b1;

      // Random stimulus against the stage model
      begin
         inst_t pe, pm, pw, d;
         int scnt = 0, fcnt = 0;
         pe = empty_i(); pm = empty_i(); pw = empty_i();
         for (int n = 0; n < 1500; n++) begin
            bit ma, rdy, br, wt, bt, lu;
            logic [6:0] ectl;
            d.v = ($urandom_range(0, 7) != 0); d.rd = rreg(); d.w = $urandom_range(0, 1);
            d.ld = $urandom_range(0, 1); d.rs1 = rreg(); d.rs2 = rreg();
            ma = $urandom_range(0, 1); rdy = ($urandom_range(0, 3) != 0);
            br = ($urandom_range(0, 7) == 0);
            drive(d.v, d.rs1, d.rs2, d.rd, d.w, d.ld, ma, rdy, br);
            @(negedge clk);
            wt = ma && !rdy && pm.v;
            bt = !wt && br && pm.v;
            lu = !wt && !bt && d.v && pe.ld && (wr_r(pe, d.rs1) || wr_r(pe, d.rs2));
            ectl = {wt || lu, wt || lu, wt, bt, bt || lu, bt, wt};
            chk($sformatf("rnd%0d ctl", n), 32'(ctl_o), 32'(ectl));
            chk($sformatf("rnd%0d fwd", n), 32'({fwdA_E, fwdB_E}),
                32'((fsel(pm, pw, pe.rs1) << 2) | fsel(pm, pw, pe.rs2)));
            if ((wt || lu) && scnt < SAT) scnt++;
            if (bt && fcnt < SAT) fcnt++;
            if (wt) pw = empty_i();
            else begin
               pw = pm;
               if (bt) begin pm = empty_i(); pe = empty_i(); end
               else begin pm = pe; pe = lu ? empty_i() : d; end
            end
            @(posedge clk); #1;
            chk($sformatf("rnd%0d cnt", n), 32'({stall_cnt, flush_cnt}),
                32'((scnt << CW) | fcnt));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
